// File: rtl/staircase_checker.sv
// Observer for the staircase counter: locks onto the 0..1, 0..2, ... 0..MAX_RAMP
// sequence, predicts each next sample, and keeps error / completed-sequence statistics.
module staircase_checker #(
  parameter int MAX_RAMP      = 9,
  parameter int STAT_W        = 8,
  parameter bit SYNC_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        count,
  output logic              locked,
  output logic [3:0]        expected,
  output logic [3:0]        ramp_max,
  output logic              err,
  output logic [STAT_W-1:0] err_cnt,
  output logic              seq_done,
  output logic [STAT_W-1:0] seq_cnt
);

  localparam logic [3:0]        MAX_V    = 4'(MAX_RAMP);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_SAT = {STAT_W{1'b1}};

  typedef enum logic {HUNT, LOCK} state_e;

  state_e            state_q;
  logic              locked_q;
  logic [3:0]        expected_q;
  logic [3:0]        ramp_max_q;
  logic              err_q;
  logic [STAT_W-1:0] err_cnt_q;
  logic              seq_done_q;
  logic [STAT_W-1:0] seq_cnt_q;
  logic [3:0]        prev_q;
  logic              first_q;

  // MAX_RAMP only ever appears at the top of the largest ramp, so MAX_RAMP then 0
  // is the one place in the stream where the position is unambiguous.
  logic hunt_hit;
  logic sample_match;
  assign hunt_hit     = (count == 4'd0) && ((first_q && SYNC_ON_RESET) || (prev_q == MAX_V));
  assign sample_match = (count == expected_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HUNT;
      locked_q   <= 1'b0;
      expected_q <= 4'd0;
      ramp_max_q <= 4'd1;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      seq_done_q <= 1'b0;
      seq_cnt_q  <= '0;
      prev_q     <= 4'd0;
      first_q    <= 1'b1;
    end else begin
      err_q      <= 1'b0;
      seq_done_q <= 1'b0;
      if (en) begin
        case (state_q)
          HUNT: begin
            if (hunt_hit) begin
              state_q    <= LOCK;
              locked_q   <= 1'b1;
              ramp_max_q <= 4'd1;
              expected_q <= 4'd1;
            end
            prev_q  <= count;
            first_q <= 1'b0;
          end
          LOCK: begin
            if (sample_match) begin
              if (expected_q < ramp_max_q) begin
                expected_q <= expected_q + 4'd1;
              end else begin
                expected_q <= 4'd0;
                if (ramp_max_q == MAX_V) begin
                  ramp_max_q <= 4'd1;
                  seq_done_q <= 1'b1;
                  seq_cnt_q  <= seq_cnt_q + STAT_ONE;
                end else begin
                  ramp_max_q <= ramp_max_q + 4'd1;
                end
              end
            end else begin
              // Any value above MAX_RAMP can never equal expected, so it lands here too.
              err_q    <= 1'b1;
              state_q  <= HUNT;
              locked_q <= 1'b0;
              prev_q   <= count;
              if (err_cnt_q != STAT_SAT) begin
                err_cnt_q <= err_cnt_q + STAT_ONE;
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked   = locked_q;
  assign expected = expected_q;
  assign ramp_max = ramp_max_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign seq_done = seq_done_q;
  assign seq_cnt  = seq_cnt_q;

endmodule

// File: tb/tb_staircase_checker.sv
// Directed bench for staircase_checker: two instances (synchronise-on-reset on and
// off) fed from one stimulus stream, expectations hand-computed from the sequence.
module tb_staircase_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] count;

  logic       locked, err, seq_done;
  logic [3:0] expected, ramp_max;
  logic [7:0] err_cnt, seq_cnt;

  logic       locked_h, err_h, seq_done_h;
  logic [3:0] expected_h, ramp_max_h;
  logic [7:0] err_cnt_h, seq_cnt_h;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [3:0] stair [0:53];

  always #5 clk = ~clk;

  staircase_checker #(.MAX_RAMP(9), .STAT_W(8), .SYNC_ON_RESET(1'b1)) dut_sync (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .locked(locked), .expected(expected), .ramp_max(ramp_max), .err(err),
    .err_cnt(err_cnt), .seq_done(seq_done), .seq_cnt(seq_cnt)
  );

  staircase_checker #(.MAX_RAMP(9), .STAT_W(8), .SYNC_ON_RESET(1'b0)) dut_hunt (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .locked(locked_h), .expected(expected_h), .ramp_max(ramp_max_h), .err(err_h),
    .err_cnt(err_cnt_h), .seq_done(seq_done_h), .seq_cnt(seq_cnt_h)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("check %s: got %0d expected %0d ok", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic e);
    count = v;
    en    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_value({tag, "_locked"},   32'(locked),   32'd0);
    check_value({tag, "_expected"}, 32'(expected), 32'd0);
    check_value({tag, "_ramp_max"}, 32'(ramp_max), 32'd1);
    check_value({tag, "_err"},      32'(err),      32'd0);
    check_value({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
    check_value({tag, "_seq_done"}, 32'(seq_done), 32'd0);
    check_value({tag, "_seq_cnt"},  32'(seq_cnt),  32'd0);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    en    = 1'b0;
    count = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Feeds stair[from..to] (one sample substituted at bad_idx); with toggle set,
  // every sample is followed by an en=0 cycle whose outputs must not move.
  task automatic run_stair(input int from_idx, input int to_idx, input int bad_idx,
                           input logic [3:0] bad_val, input bit toggle,
                           output int errs, output int dones, output int unlocked,
                           output int hold_bad);
    logic [3:0]  v;
    logic [24:0] snap;
    errs = 0; dones = 0; unlocked = 0; hold_bad = 0;
    for (int k = from_idx; k <= to_idx; k++) begin
      v = (k == bad_idx) ? bad_val : stair[k];
      step(v, 1'b1);
      errs  += int'(err);
      dones += int'(seq_done);
      if (!locked) unlocked++;
      if (toggle) begin
        snap = {locked, expected, ramp_max, err_cnt, seq_cnt};
        step(v, 1'b0);
        if (snap != {locked, expected, ramp_max, err_cnt, seq_cnt} || err || seq_done)
          hold_bad++;
      end
    end
  endtask

  initial begin
    int idx, errs, dones, unlocked, hold_bad, pulses, hunt_bad;
    idx = 0;
    for (int r = 1; r <= 9; r++)
      for (int i = 0; i <= r; i++) begin
        stair[idx] = 4'(i);
        idx++;
      end

    // Reset values, then one full staircase from power-up
    do_reset();
    check_reset("reset");
    step(stair[0], 1'b1);
    check_value("t1_locked_first", 32'(locked), 32'd1);
    check_value("t1_expected_first", 32'(expected), 32'd1);
    run_stair(1, 53, -1, 4'd0, 1'b0, errs, dones, unlocked, hold_bad);
    check_value("t1_err_pulses", 32'(errs), 32'd0);
    check_value("t1_done_pulses", 32'(dones), 32'd1);
    check_value("t1_done_last", 32'(seq_done), 32'd1);
    check_value("t1_unlocked", 32'(unlocked), 32'd0);
    check_value("t1_seq_cnt", 32'(seq_cnt), 32'd1);
    check_value("t1_ramp_max", 32'(ramp_max), 32'd1);
    check_value("t1_expected", 32'(expected), 32'd0);

    // Corrupt sample: 5 in place of 3 in ramp 0..4 (stair index 12)
    run_stair(0, 53, 12, 4'd5, 1'b0, errs, dones, unlocked, hold_bad);
    check_value("t2_err_pulses", 32'(errs), 32'd1);
    check_value("t2_err_cnt", 32'(err_cnt), 32'd1);
    check_value("t2_locked", 32'(locked), 32'd0);
    check_value("t2_done_pulses", 32'(dones), 32'd0);
    run_stair(0, 53, -1, 4'd0, 1'b0, errs, dones, unlocked, hold_bad);
    check_value("t2_relock_unlocked", 32'(unlocked), 32'd0);
    check_value("t2_relock_errs", 32'(errs), 32'd0);
    check_value("t2_seq_cnt", 32'(seq_cnt), 32'd2);

    // No sync on reset: mid-ramp start (from the 2 of ramp 0..3) must hunt until 9,0
    do_reset();
    hunt_bad = 0;
    for (int k = 7; k <= 53; k++) begin
      step(stair[k], 1'b1);
      if (locked_h || err_h) hunt_bad++;
    end
    check_value("t3_hunt_quiet", 32'(hunt_bad), 32'd0);
    step(4'd0, 1'b1);
    check_value("t3_locked", 32'(locked_h), 32'd1);
    check_value("t3_expected", 32'(expected_h), 32'd1);

    // en toggling over a clean staircase
    do_reset();
    run_stair(0, 53, -1, 4'd0, 1'b1, errs, dones, unlocked, hold_bad);
    check_value("t4_err_pulses", 32'(errs), 32'd0);
    check_value("t4_done_pulses", 32'(dones), 32'd1);
    check_value("t4_unlocked", 32'(unlocked), 32'd0);
    check_value("t4_hold", 32'(hold_bad), 32'd0);
    check_value("t4_seq_cnt", 32'(seq_cnt), 32'd1);

    // Out-of-range inject, then saturate err_cnt with 300 mismatches in total
    do_reset();
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    check_value("t5_expected_pre", 32'(expected), 32'd0);
    step(4'd12, 1'b1);
    check_value("t5_err", 32'(err), 32'd1);
    check_value("t5_locked", 32'(locked), 32'd0);
    check_value("t5_err_cnt", 32'(err_cnt), 32'd1);
    step(4'd9, 1'b1);
    check_value("t5_err_one_cycle", 32'(err), 32'd0);
    pulses = 0;
    for (int n = 0; n < 299; n++) begin
      if (n != 0) step(4'd9, 1'b1);
      step(4'd0, 1'b1);
      step(4'd12, 1'b1);
      pulses += int'(err);
    end
    check_value("t5_loop_pulses", 32'(pulses), 32'd299);
    check_value("t5_err_cnt_sat", 32'(err_cnt), 32'd255);

    // Async reset between edges while locked mid-ramp 0..6
    step(4'd9, 1'b1);
    run_stair(0, 23, -1, 4'd0, 1'b0, errs, dones, unlocked, hold_bad);
    check_value("t6_unlocked", 32'(unlocked), 32'd0);
    check_value("t6_expected", 32'(expected), 32'd4);
    check_value("t6_ramp_max", 32'(ramp_max), 32'd6);
    #2;
    rst = 1'b0;
    #1;
    check_reset("t6_async");
    #2;
    rst = 1'b1;
    step(4'd0, 1'b1);
    check_value("t6_relock", 32'(locked), 32'd1);
    check_value("t6_relock_expected", 32'(expected), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
